// File: rtl/countdown_alarm.sv
// countdown_alarm: watches the countdown timer's time outputs. When the count
// steps naturally from 00:00:01 to 00:00:00 it sounds a burst-cadence buzzer.
// The alarm stops when ack is pressed or when the auto-silence timeout expires.
// After that, the expired status is held until a nonzero time is loaded again.
module countdown_alarm #(
    parameter int BEEP_ON_TICKS   = 10_000_000,
    parameter int BEEP_OFF_TICKS  = 10_000_000,
    parameter int BEEPS_PER_BURST = 4,
    parameter int GAP_TICKS       = 25_000_000,
    parameter int SEC_TICKS       = 50_000_000,
    parameter int TIMEOUT_S       = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] secs,
    input  logic [7:0] mins,
    input  logic [7:0] hours,
    input  logic       ack,
    output logic       buzzer,
    output logic       alarm_active,
    output logic       expired,
    output logic       timed_out
);

    localparam int MAX_ON_OFF = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
    localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
    localparam int TW = $clog2(MAX_TICKS + 1);
    localparam int BW = $clog2(BEEPS_PER_BURST + 1);
    localparam int PW = $clog2(SEC_TICKS + 1);
    localparam int SW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {IDLE, ARMED, BEEP_ON, BEEP_OFF, GAP, DONE} state_t;

    state_t        state;
    logic [23:0]   cur_time;
    logic [23:0]   prev_time;
    logic          ack_prev;
    logic [TW-1:0] tick;
    logic [BW-1:0] beep;
    logic [PW-1:0] presc;
    logic [SW-1:0] sec_cnt;
    logic          timeout_flag;

    logic zero, trigger, ack_edge, sec_wrap, timeout;

    assign cur_time = {hours, mins, secs};
    assign zero     = (cur_time == 24'd0);
    // Only a natural 1 -> 0 step fires the alarm. A clear or a wrap to zero does not.
    assign trigger  = zero && (prev_time == 24'h00_00_01);
    assign ack_edge = ack && !ack_prev;
    assign sec_wrap = (presc == PW'(SEC_TICKS - 1));
    assign timeout  = sec_wrap && (sec_cnt == SW'(TIMEOUT_S - 1));

    // Outputs are decoded from registered state only, so no input reaches an output combinationally.
    assign buzzer       = (state == BEEP_ON);
    assign alarm_active = (state == BEEP_ON) || (state == BEEP_OFF) || (state == GAP);
    assign expired      = (state == DONE);
    assign timed_out    = (state == DONE) && timeout_flag;

    // Main FSM: expiry detection, beep cadence, and the timeout prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prev_time    <= '0;
            ack_prev     <= 1'b1;   // a button held through reset must not count as an edge
            tick         <= '0;
            beep         <= '0;
            presc        <= '0;
            sec_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            prev_time <= cur_time;
            ack_prev  <= ack;
            case (state)
                IDLE: begin
                    if (!zero) state <= ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        state   <= BEEP_ON;
                        tick    <= '0;
                        beep    <= '0;
                        presc   <= '0;
                        sec_cnt <= '0;
                    end else if (zero) begin
                        state <= IDLE;
                    end
                end
                BEEP_ON, BEEP_OFF, GAP: begin
                    if (!zero) begin
                        // A new time was loaded: go silent and re-arm.
                        state <= ARMED;
                    end else if (ack_edge) begin
                        // ack takes priority over a timeout in the same cycle.
                        state        <= DONE;
                        timeout_flag <= 1'b0;
                    end else if (timeout) begin
                        state        <= DONE;
                        timeout_flag <= 1'b1;
                    end else begin
                        if (sec_wrap) begin
                            presc   <= '0;
                            sec_cnt <= sec_cnt + 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (state == BEEP_ON) begin
                            if (tick == TW'(BEEP_ON_TICKS - 1)) begin
                                state <= BEEP_OFF;
                                beep  <= beep + 1'b1;
                                tick  <= '0;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end else if (state == BEEP_OFF) begin
                            if (tick == TW'(BEEP_OFF_TICKS - 1)) begin
                                state <= (beep == BW'(BEEPS_PER_BURST)) ? GAP : BEEP_ON;
                                tick  <= '0;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end else begin
                            if (tick == TW'(GAP_TICKS - 1)) begin
                                state <= BEEP_ON;
                                beep  <= '0;
                                tick  <= '0;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!zero) begin
                        state        <= ARMED;
                        timeout_flag <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_alarm.sv
// Directed bench for countdown_alarm, using small cadence/timeout parameters.
// It applies a vector table one clock per entry, then runs a few hand sequences.
module tb_countdown_alarm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] secs, mins, hours;
    logic       ack;
    logic       buzzer, alarm_active, expired, timed_out;

    countdown_alarm #(
        .BEEP_ON_TICKS(3), .BEEP_OFF_TICKS(2), .BEEPS_PER_BURST(2),
        .GAP_TICKS(5), .SEC_TICKS(10), .TIMEOUT_S(3)
    ) dut (
        .clk(clk), .reset(reset), .secs(secs), .mins(mins), .hours(hours),
        .ack(ack), .buzzer(buzzer), .alarm_active(alarm_active),
        .expired(expired), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s, m, h;
        logic       a, r;
        logic       bz, act, ex, to;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    // Buzzer level by alarm cycle: 3 high, 2 low, 3 high, 2 low, 5 low.
    logic [14:0] pat = 15'h00E7;

    function automatic void add(input int s, input int m, input int h,
                                input logic a, input logic r,
                                input logic bz, input logic act,
                                input logic ex, input logic to);
        vec_t v;
        v.s = 8'(s); v.m = 8'(m); v.h = 8'(h);
        v.a = a; v.r = r; v.bz = bz; v.act = act; v.ex = ex; v.to = to;
        vecs.push_back(v);
    endfunction

    task automatic step(input int s, input int m, input int h,
                        input logic a, input logic r);
        secs = 8'(s); mins = 8'(m); hours = 8'(h); ack = a; reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic bz, input logic act,
                       input logic ex, input logic to);
        checks++;
        if ({buzzer, alarm_active, expired, timed_out} !== {bz, act, ex, to}) begin
            errors++;
            $display("FAIL %s: got buzzer=%b active=%b expired=%b timed_out=%b, want %b %b %b %b",
                     name, buzzer, alarm_active, expired, timed_out, bz, act, ex, to);
        end
    endtask

    initial begin
        // ---- table: reset, trigger, cadence, timeout, reload
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 30; p++) add(0, 0, 0, 0, 0, pat[p % 15], 1'b1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);       // 00:01:00 re-arms
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);       // 00:01:00 -> 0 is not an expiry
        // ---- ack edge at alarm cycle 7, then ack held
        add(2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 7; p++) add(0, 0, 0, 0, 0, pat[p], 1'b1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        // ---- user clear and seconds wrap do not fire
        add(30, 5, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(59, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ---- load nonzero mid-alarm silences and re-arms
        add(2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s, vecs[i].m, vecs[i].h, vecs[i].a, vecs[i].r);
            chk($sformatf("vec%0d", i), vecs[i].bz, vecs[i].act, vecs[i].ex, vecs[i].to);
        end

        // ---- reset mid-alarm with time at zero: no re-fire until a fresh 1 -> 0
        step(2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); chk("rst_pre_on", 1, 1, 0, 0);
        step(0, 0, 0, 0, 1); chk("rst_mid", 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0, 0); chk("no_refire", 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0); chk("fresh_arm", 0, 0, 0, 0);
        // ---- the same alarm feeds the ack/timeout tie
        step(0, 0, 0, 0, 0); chk("fresh_fire", 1, 1, 0, 0);
        for (int k = 1; k < 30; k++) step(0, 0, 0, 0, 0);
        chk("tie_pre", pat[29 % 15], 1, 0, 0);
        step(0, 0, 0, 1, 0); chk("ack_timeout_tie", 0, 0, 1, 0);

        // ---- ack held through reset release is not an edge
        step(0, 0, 0, 1, 1); chk("ackhold_rst", 0, 0, 0, 0);
        step(2, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0); chk("ackhold_fire", 1, 1, 0, 0);
        for (int p = 1; p < 4; p++) begin
            step(0, 0, 0, 1, 0); chk("ackhold_no_edge", pat[p], 1, 0, 0);
        end
        step(0, 0, 0, 0, 0); chk("ack_release", pat[4], 1, 0, 0);
        step(0, 0, 0, 1, 0); chk("ack_new_edge", 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
